// File: rtl/mio_bus_mk2_pkg.sv
`default_nettype none
// mio_pkg: address map, control-register offsets, status bit positions and VRAM FSM states.
// Revision 2.0
package mio_pkg;

  localparam logic [31:0] c_VRAM_BASE = 32'hC000_0000;
  localparam logic [31:0] c_VRAM_MASK = 32'hE000_0000;
  localparam logic [31:0] c_SEG_BASE  = 32'h0000_7F10;
  localparam logic [31:0] c_SEG_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] c_ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] c_ROM_MASK  = 32'hFFFF_F800;
  localparam logic [31:0] c_RAM_BASE  = 32'h0000_0800;
  localparam logic [31:0] c_RAM_MASK  = 32'hFFFF_F800;
  localparam logic [31:0] c_CTRL_BASE = 32'h0000_1000;
  localparam logic [31:0] c_CTRL_MASK = 32'hFFFF_FFE0;

  localparam logic [2:0] c_REG_CUR_ROW    = 3'd0;
  localparam logic [2:0] c_REG_CUR_COL    = 3'd1;
  localparam logic [2:0] c_REG_TMR_CNT    = 3'd2;
  localparam logic [2:0] c_REG_TMR_PERIOD = 3'd3;
  localparam logic [2:0] c_REG_TMR_CTRL   = 3'd4;
  localparam logic [2:0] c_REG_KBD_DATA   = 3'd5;
  localparam logic [2:0] c_REG_KBD_STAT   = 3'd6;

  localparam int c_STAT_EMPTY    = 0;
  localparam int c_STAT_FULL     = 1;
  localparam int c_STAT_OVF      = 2;
  localparam int c_STAT_CNT_LSB  = 8;
  localparam int c_TCTRL_IRQ_EN  = 0;
  localparam int c_TCTRL_WRAP    = 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } vram_state_e;

  function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] mask);
    return (a & mask) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mio_bus_mk2_kbd_fifo.sv
`default_nettype none
// mio_kbd_fifo: scancode FIFO with wrapping pointers and a sticky overflow flag.
// Revision 2.0
module mio_kbd_fifo
  import mio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  input  logic                     i_clr_ovf,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] c_FULL    = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_FULL);
  assign w_pop     = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = i_push & (~o_full | w_pop);
  assign w_drop    = i_push & o_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mio_bus_mk2.sv
`default_nettype none
// mio_bus_mk2: CPU data-port fabric with VRAM wait states, keyboard FIFO, timer and control registers.
// Revision 2.0
module mio_bus_mk2
  import mio_pkg::*;
#(
  parameter int RAM_AW         = 6,
  parameter int KBD_DEPTH      = 8,
  parameter int VRAM_WAIT      = 1,
  parameter int TMR_PRESCALE   = 16,
  parameter int TMR_PERIOD_RST = 62500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       i_mem_a,
  input  logic [31:0]       i_d_t_mem,
  output logic [31:0]       o_d_f_mem,
  input  logic              i_wmem,
  input  logic              i_rmem,
  output logic              o_mem_ready,
  output logic              o_irq,
  output logic [31:0]       o_vga_a,
  output logic [31:0]       o_d_t_vga,
  input  logic [6:0]        i_d_f_vga,
  output logic              o_wvram,
  output logic              o_rvram,
  input  logic              i_kbd_valid,
  input  logic [7:0]        i_kbd_data,
  output logic [31:0]       o_d_t_seg,
  output logic              o_wseg,
  input  logic [31:0]       i_d_f_seg,
  output logic [31:0]       o_rom_a,
  input  logic [31:0]       i_d_f_rom,
  output logic [RAM_AW-1:0] o_ram_a,
  output logic [31:0]       o_d_t_ram,
  output logic              o_wram,
  input  logic [31:0]       i_d_f_ram
);

  localparam int c_PW  = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
  localparam int c_KCW = $clog2(KBD_DEPTH) + 1;
  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TMR_PRESCALE - 1);
  localparam logic [c_PW-1:0] c_PRE_ONE = c_PW'(1);
  localparam logic [3:0]      c_VWAIT   = 4'(VRAM_WAIT);

  logic w_vram, w_seg, w_rom, w_ram, w_ctrl, w_access, w_ready;
  logic w_wr_reg, w_rd_reg, w_period_wr, w_pre_wrap, w_tmr_hit;
  logic [2:0] w_off;
  logic [31:0] w_reg_rd, w_rdata;
  vram_state_e r_state, w_state_nxt;
  logic [3:0] r_wcnt, w_wcnt_nxt;

  logic [31:0] r_row, r_col, r_period, r_tcnt;
  logic [c_PW-1:0] r_pre;
  logic r_irq_en, r_flag, r_irq;

  logic [7:0] w_khead;
  logic [c_KCW-1:0] w_kcount;
  logic w_kfull, w_kempty, w_kovf;

  // First match wins: each region is masked by every earlier one.
  assign w_vram = in_region(i_mem_a, c_VRAM_BASE, c_VRAM_MASK);
  assign w_seg  = ~w_vram & in_region(i_mem_a, c_SEG_BASE, c_SEG_MASK);
  assign w_rom  = ~w_vram & ~w_seg & in_region(i_mem_a, c_ROM_BASE, c_ROM_MASK);
  assign w_ram  = ~w_vram & ~w_seg & ~w_rom & in_region(i_mem_a, c_RAM_BASE, c_RAM_MASK);
  assign w_ctrl = ~w_vram & ~w_seg & ~w_rom & ~w_ram & in_region(i_mem_a, c_CTRL_BASE, c_CTRL_MASK);
  assign w_access = i_rmem | i_wmem;
  assign w_off    = i_mem_a[4:2];

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_ready     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_access && w_vram && (c_VWAIT != 4'd0)) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = c_VWAIT;
          w_ready     = 1'b0;
        end
      end
      S_WAIT: begin
        w_wcnt_nxt = r_wcnt - 4'd1;
        if (r_wcnt == 4'd1) w_state_nxt = S_IDLE;
        else                w_ready     = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst_n) w_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  assign w_wr_reg    = i_wmem & w_ctrl & w_ready;
  assign w_rd_reg    = i_rmem & w_ctrl & w_ready;
  assign w_period_wr = w_wr_reg & (w_off == c_REG_TMR_PERIOD);
  assign w_pre_wrap  = (r_pre == c_PRE_MAX);
  assign w_tmr_hit   = w_pre_wrap & (r_tcnt == r_period) & ~w_period_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row    <= 32'h0;
      r_col    <= 32'h0;
      r_period <= 32'(TMR_PERIOD_RST);
      r_tcnt   <= 32'h0;
      r_pre    <= '0;
      r_irq_en <= 1'b0;
      r_flag   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_reg && w_off == c_REG_CUR_ROW) r_row <= i_d_t_mem;
      if (w_wr_reg && w_off == c_REG_CUR_COL) r_col <= i_d_t_mem;
      if (w_period_wr) begin
        r_period <= i_d_t_mem;
        r_pre    <= '0;
        r_tcnt   <= 32'h0;
      end else if (w_pre_wrap) begin
        r_pre  <= '0;
        r_tcnt <= (r_tcnt == r_period) ? 32'h0 : r_tcnt + 32'd1;
      end else begin
        r_pre <= r_pre + c_PRE_ONE;
      end
      if (w_wr_reg && w_off == c_REG_TMR_CTRL) r_irq_en <= i_d_t_mem[c_TCTRL_IRQ_EN];
      // A wrap in the same cycle as the write-1-to-clear keeps the flag set.
      if (w_tmr_hit) r_flag <= 1'b1;
      else if (w_wr_reg && w_off == c_REG_TMR_CTRL && i_d_t_mem[c_TCTRL_WRAP]) r_flag <= 1'b0;
      r_irq <= r_irq_en & r_flag;
    end
  end

  mio_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (i_kbd_valid),
    .i_data    (i_kbd_data),
    .i_pop     (w_rd_reg & (w_off == c_REG_KBD_DATA)),
    .i_clr_ovf (w_wr_reg & (w_off == c_REG_KBD_STAT)),
    .o_head    (w_khead),
    .o_count   (w_kcount),
    .o_full    (w_kfull),
    .o_empty   (w_kempty),
    .o_ovf     (w_kovf)
  );

  always_comb begin
    w_reg_rd = 32'h0;
    case (w_off)
      c_REG_CUR_ROW:    w_reg_rd = r_row;
      c_REG_CUR_COL:    w_reg_rd = r_col;
      c_REG_TMR_CNT:    w_reg_rd = r_tcnt;
      c_REG_TMR_PERIOD: w_reg_rd = r_period;
      c_REG_TMR_CTRL:   w_reg_rd = {30'h0, r_flag, r_irq_en};
      c_REG_KBD_DATA:   w_reg_rd = {24'h0, w_khead};
      c_REG_KBD_STAT:   w_reg_rd = {16'h0, 8'(w_kcount), 5'h0, w_kovf, w_kfull, w_kempty};
      default:          w_reg_rd = 32'h0;
    endcase
    w_rdata = 32'h0;
    if (w_vram)      w_rdata = {25'h0, i_d_f_vga};
    else if (w_seg)  w_rdata = i_d_f_seg;
    else if (w_rom)  w_rdata = i_d_f_rom;
    else if (w_ram)  w_rdata = i_d_f_ram;
    else if (w_ctrl) w_rdata = w_reg_rd;
  end

  assign o_d_f_mem   = w_rdata;
  assign o_mem_ready = w_ready;
  assign o_irq       = r_irq;
  assign o_vga_a     = i_mem_a;
  assign o_d_t_vga   = i_d_t_mem;
  assign o_wvram     = i_wmem & w_vram & w_ready;
  assign o_rvram     = i_rmem & w_vram;
  assign o_d_t_seg   = i_d_t_mem;
  assign o_wseg      = i_wmem & w_seg;
  assign o_rom_a     = i_mem_a;
  assign o_ram_a     = i_mem_a[RAM_AW+1:2];
  assign o_d_t_ram   = i_d_t_mem;
  assign o_wram      = i_wmem & w_ram;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_mk2.sv
`default_nettype none
// tb_mio_bus_mk2: randomized scoreboard bench for mio_bus_mk2 against a queue/arithmetic reference model.
// Revision 2.0
module tb_mio_bus_mk2;

  localparam int VW = 2;
  localparam int KD = 8;
  localparam int PRE = 16;
  localparam int R_NONE = 0, R_VRAM = 1, R_SEG = 2, R_ROM = 3, R_RAM = 4, R_CTRL = 5;

  logic clk = 1'b0;
  logic rst_n, wmem, rmem, kbd_valid;
  logic [31:0] mem_a, d_t_mem, d_f_seg, d_f_rom, d_f_ram;
  logic [6:0] d_f_vga;
  logic [7:0] kbd_data;
  logic [31:0] o_d_f_mem, o_vga_a, o_d_t_vga, o_d_t_seg, o_rom_a, o_d_t_ram;
  logic o_mem_ready, o_irq, o_wvram, o_rvram, o_wseg, o_wram;
  logic [5:0] o_ram_a;

  always #5 clk = ~clk;

  mio_bus_mk2 #(.RAM_AW(6), .KBD_DEPTH(KD), .VRAM_WAIT(VW), .TMR_PRESCALE(PRE),
                .TMR_PERIOD_RST(62500)) dut (
    .clk(clk), .rst_n(rst_n), .i_mem_a(mem_a), .i_d_t_mem(d_t_mem), .o_d_f_mem(o_d_f_mem),
    .i_wmem(wmem), .i_rmem(rmem), .o_mem_ready(o_mem_ready), .o_irq(o_irq),
    .o_vga_a(o_vga_a), .o_d_t_vga(o_d_t_vga), .i_d_f_vga(d_f_vga), .o_wvram(o_wvram),
    .o_rvram(o_rvram), .i_kbd_valid(kbd_valid), .i_kbd_data(kbd_data),
    .o_d_t_seg(o_d_t_seg), .o_wseg(o_wseg), .i_d_f_seg(d_f_seg), .o_rom_a(o_rom_a),
    .i_d_f_rom(d_f_rom), .o_ram_a(o_ram_a), .o_d_t_ram(o_d_t_ram), .o_wram(o_wram),
    .i_d_f_ram(d_f_ram)
  );

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic [2:0]  strb;
    logic [5:0]  ram_a;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_row, m_col, m_period;
  longint m_tk;
  bit m_flag, m_irq_en, m_irq, m_ovf;
  logic [7:0] m_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int region(input logic [31:0] a);
    if (a >= 32'hC000_0000 && a <= 32'hDFFF_FFFF) return R_VRAM;
    if (a >= 32'h0000_7F10 && a <= 32'h0000_7F1F) return R_SEG;
    if (a <= 32'h0000_07FF) return R_ROM;
    if (a >= 32'h0000_0800 && a <= 32'h0000_0FFF) return R_RAM;
    if (a >= 32'h0000_1000 && a <= 32'h0000_101F) return R_CTRL;
    return R_NONE;
  endfunction

  function automatic logic [31:0] exp_read(input int r, input int off);
    case (r)
      R_VRAM: return {25'h0, d_f_vga};
      R_SEG:  return d_f_seg;
      R_ROM:  return d_f_rom;
      R_RAM:  return d_f_ram;
      R_CTRL: begin
        case (off)
          0: return m_row;
          1: return m_col;
          2: return 32'((m_tk / PRE) % (longint'(m_period) + 1));
          3: return m_period;
          4: return {30'h0, m_flag, m_irq_en};
          5: return (m_q.size() > 0) ? {24'h0, m_q[0]} : 32'h0;
          6: return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == KD, m_q.size() == 0};
          default: return 32'h0;
        endcase
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_period = 32'd62500; m_tk = 0;
    m_flag = 0; m_irq_en = 0; m_irq = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // One clock: drive at posedge+1, check combinational outputs, advance model at the posedge.
  task automatic tick(input bit rstn, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit kv, input logic [7:0] kd, input bit rdy);
    int r, off;
    exp_t e;
    bit pop, irq_nxt, wr_ctrl;
    rst_n = rstn; rmem = rd; wmem = wr; mem_a = addr; d_t_mem = wd;
    kbd_valid = kv; kbd_data = kd;
    d_f_rom = $urandom; d_f_ram = $urandom; d_f_seg = $urandom; d_f_vga = 7'($urandom);
    r = region(addr);
    off = int'(addr[4:2]);
    #1;
    chk("mem_ready", 32'(o_mem_ready), 32'(rdy));
    chk("rvram", 32'(o_rvram), 32'(rd && r == R_VRAM));
    if (!rdy) chk("wvram_during_wait", 32'(o_wvram), 32'h0);
    if (rstn && rdy && (rd || wr)) begin
      e.rd = rd;
      e.data = rd ? exp_read(r, off) : wd;
      e.strb = {wr && r == R_VRAM, wr && r == R_SEG, wr && r == R_RAM};
      e.ram_a = addr[7:2];
      sb.push_back(e);
    end
    pop = rstn && rdy && rd && r == R_CTRL && off == 5 && m_q.size() > 0;
    wr_ctrl = rdy && wr && r == R_CTRL;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      irq_nxt = m_irq_en & m_flag;
      if (wr_ctrl) begin
        case (off)
          0: m_row = wd;
          1: m_col = wd;
          3: m_period = wd;
          4: begin m_irq_en = wd[0]; if (wd[1]) m_flag = 0; end
          6: m_ovf = 0;
          default: ;
        endcase
      end
      if (pop) void'(m_q.pop_front());
      if (kv) begin
        if (m_q.size() == KD) m_ovf = 1;
        else m_q.push_back(kd);
      end
      if (wr_ctrl && off == 3) m_tk = 0;
      else begin
        m_tk++;
        if (m_tk % (PRE * (longint'(m_period) + 1)) == 0) m_flag = 1;
      end
      m_irq = irq_nxt;
    end
    #1;
    chk("irq", 32'(o_irq), 32'(m_irq));
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd = 0, input bit kv = 0, input logic [7:0] kd = 0);
    if (region(a) == R_VRAM)
      for (int i = 0; i < VW; i++) tick(1, rd, wr, a, wd, 0, 8'h0, 0);
    tick(1, rd, wr, a, wd, kv, kd, 1);
  endtask

  task automatic idle(input bit kv = 0, input logic [7:0] kd = 0);
    tick(1, 0, 0, 32'h0000_3000, 32'h0, kv, kd, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_mem_ready && (rmem || wmem)) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_underflow: got access at %h expected none", mem_a);
        end else begin
          e = sb.pop_front();
          if (e.rd) chk("rdata", o_d_f_mem, e.data);
          else if (e.strb[2]) chk("d_t_vga", o_d_t_vga, e.data);
          else if (e.strb[1]) chk("d_t_seg", o_d_t_seg, e.data);
          else if (e.strb[0]) chk("d_t_ram", o_d_t_ram, e.data);
          chk("strobes", {29'h0, o_wvram, o_wseg, o_wram}, {29'h0, e.strb});
          if (e.strb[0]) chk("ram_a", 32'(o_ram_a), 32'(e.ram_a));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, wd;
    bit rd;
    model_reset();
    rst_n = 0; rmem = 0; wmem = 0; mem_a = 0; d_t_mem = 0; kbd_valid = 0; kbd_data = 0;
    d_f_vga = 0; d_f_seg = 0; d_f_rom = 0; d_f_ram = 0;
    @(posedge clk); #1;
    tick(0, 0, 0, 32'h3000, 0, 0, 0, 1);
    tick(0, 0, 0, 32'h3000, 0, 0, 0, 1);
    // Reset state of the register file
    access(1, 0, 32'h1000); access(1, 0, 32'h100C);
    access(1, 0, 32'h1018); access(1, 0, 32'h1010);

    // VRAM wait-state handshake
    access(0, 1, 32'hC000_0010, 32'h41);
    access(1, 0, 32'hC000_0020);

    // Keyboard basic push/pop and empty read
    idle(1, 8'h1C); idle(1, 8'h32);
    access(1, 0, 32'h1014); access(1, 0, 32'h1014); access(1, 0, 32'h1014);
    access(1, 0, 32'h1018);

    // Overflow, overflow clear, push+pop while full
    for (int i = 0; i < 9; i++) idle(1, 8'(8'h40 + i));
    access(1, 0, 32'h1018);
    access(0, 1, 32'h1018, 32'h0);
    access(1, 0, 32'h1018);
    access(1, 0, 32'h1014, 0, 1, 8'h77);
    access(1, 0, 32'h1018);
    for (int i = 0; i < 8; i++) access(1, 0, 32'h1014);
    access(1, 0, 32'h1018);

    // Timer: period 3, irq enabled, W1C, then period 0
    access(0, 1, 32'h100C, 32'd3);
    access(0, 1, 32'h1010, 32'h1);
    repeat (66) idle();
    access(1, 0, 32'h1010);
    access(0, 1, 32'h1010, 32'h3);
    repeat (3) idle();
    access(1, 0, 32'h1008);
    repeat (64) idle();
    access(1, 0, 32'h1010);
    access(0, 1, 32'h100C, 32'd0);
    repeat (20) idle();
    access(1, 0, 32'h1010);

    // Decode
    access(1, 0, 32'h0000_0004);
    access(1, 0, 32'h0000_0804);
    access(0, 1, 32'h0000_0804, 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_7F10);
    access(0, 1, 32'h0000_7F14, 32'h1234_5678);
    access(1, 0, 32'h0000_101C);
    access(0, 1, 32'h0000_2000, 32'h5555_AAAA);
    access(1, 0, 32'h0000_2000);

    // Randomized traffic across all regions
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 6))
        0: a = 32'($urandom_range(0, 32'h7FF));
        1: a = 32'h800 + 32'($urandom_range(0, 32'h7FF));
        2: a = 32'h7F10 + 32'($urandom_range(0, 15));
        3, 4: a = 32'h1000 + 32'($urandom_range(0, 31));
        5: a = 32'hC000_0000 + ($urandom & 32'h1FFF_FFFF);
        default: a = 32'h2000 + 32'($urandom_range(0, 32'hFFFF));
      endcase
      rd = ($urandom_range(0, 1) == 1);
      wd = $urandom;
      if (region(a) == R_CTRL && a[4:2] == 3'd3) wd = 32'($urandom_range(0, 7));
      access(rd, !rd, a, wd, $urandom_range(0, 3) == 0, 8'($urandom));
    end

    // Reset in the middle of a VRAM wait with three entries queued
    access(0, 1, 32'h1018, 32'h0);
    while (m_q.size() > 0) access(1, 0, 32'h1014);
    idle(1, 8'h11); idle(1, 8'h22); idle(1, 8'h33);
    access(0, 1, 32'h1000, 32'h5);
    tick(1, 1, 0, 32'hC000_0004, 0, 0, 0, 0);
    tick(0, 0, 0, 32'h3000, 0, 0, 0, 1);
    idle();
    access(1, 0, 32'h1018); access(1, 0, 32'h1000); access(1, 0, 32'h100C);
    idle(); idle();

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mio_bus_mk2.md
Name: mio_bus_mk2

Overview:
- Parametrised memory/IO bus fabric between the CPU data port and the memory-mapped slaves: ROM, RAM, VRAM, 7-segment, keyboard.
- Successor to the first-generation decoder. Adds:
  - a VRAM wait-state handshake;
  - a buffered keyboard FIFO;
  - a programmable timer with interrupt;
  - word-aligned internal control registers.
- Sits between the CPU memory stage and all slaves; all returned read data passes through its mux.

Parameters:
- RAM_AW, 6: RAM word-address width; ram_a = mem_a[RAM_AW+1:2].
- KBD_DEPTH, 8: keyboard FIFO entries; must be a power of 2, ≥2.
- VRAM_WAIT, 1: stall cycles per VRAM access; range 0..15.
- TMR_PRESCALE, 16: clk cycles per timer count.
- TMR_PERIOD_RST, 62500: reset value of the period register.

Ports:
- clk in 1: system clock; all state is updated on posedge.
- rst_n in 1: synchronous, active-low reset.
- mem_a in 32: CPU byte address.
- d_t_mem in 32: CPU write data.
- d_f_mem out 32: read data to the CPU.
- wmem in 1: CPU write strobe.
- rmem in 1: CPU read strobe.
- mem_ready out 1: high = access completes this cycle.
- irq out 1: timer interrupt, level.
- vga_a out 32: VRAM address (= mem_a).
- d_t_vga out 32: VRAM write data.
- d_f_vga in 7: VRAM read character.
- wvram out 1: VRAM write.
- rvram out 1: VRAM read.
- kbd_valid in 1: one-cycle pulse; new scancode present.
- kbd_data in 8: scancode.
- d_t_seg out 32: segment display data.
- wseg out 1: segment write.
- d_f_seg in 32: segment readback.
- rom_a out 32: ROM address.
- d_f_rom in 32: ROM data.
- ram_a out RAM_AW: RAM word address.
- d_t_ram out 32: RAM write data.
- wram out 1: RAM write.
- d_f_ram in 32: RAM data.

Behaviour:
- Reset: synchronous and active-low — state clears on the posedge clk where rst_n=0.

Address map, first match wins:
- VRAM: C000_0000–DFFF_FFFF.
- SEG: 0000_7F10–0000_7F1F.
- ROM: 0000_0000–0000_07FF.
- RAM: 0000_0800–0000_0FFF.
- CTRL registers: 0000_1000–0000_101F, decoded on mem_a[4:2]; mem_a[1:0] ignored.
- Unmapped: reads return 0, writes are ignored.

Control registers:
- 0x1000 CUR_ROW, RW 32 bit, reset 0.
- 0x1004 CUR_COL, RW 32 bit, reset 0.
- 0x1008 TMR_CNT, RO.
- 0x100C TMR_PERIOD, RW, reset TMR_PERIOD_RST. A write also clears TMR_CNT and the prescaler.
- 0x1010 TMR_CTRL:
  - bit0 irq_en, RW;
  - bit1 wrap flag, write-1-to-clear.
- 0x1014 KBD_DATA, RO: {24'h0, head}. A read pops one entry.
- 0x1018 KBD_STAT, RO: {count[15:8], 5'h0, overflow, full, empty}. Any write to 0x1018 clears overflow.
- 0x101C: reserved, reads 0.

VRAM handshake:
- FSM states: IDLE and WAIT; 4-bit wait counter.
- In IDLE, (rmem|wmem) on VRAM with VRAM_WAIT>0:
  - go to WAIT and load counter = VRAM_WAIT;
  - mem_ready=0 that cycle.
- In WAIT: decrement each cycle; mem_ready=0 while counter≠0.
  - When counter reaches 0: mem_ready=1 for one cycle, then return to IDLE.
- Total VRAM access latency is VRAM_WAIT+1 cycles.
- rvram = rmem & vram for every cycle of the access.
- wvram = wmem & vram & mem_ready, so it pulses exactly once.
- VRAM_WAIT=0: mem_ready stays 1 and the FSM never leaves IDLE.
- Non-VRAM accesses: mem_ready=1 combinationally.
- The CPU holds mem_a, rmem and wmem stable while mem_ready=0.
- Reset mid-wait returns to IDLE with mem_ready=1.

Side effects:
- Register writes, the KBD pop, and W1C all qualify on mem_ready=1 at the posedge.
- wram, wseg and ram_a are combinational decodes, as in the first generation.

Keyboard FIFO:
- KBD_DEPTH entries with wrapping pointers; count is clog2(KBD_DEPTH)+1 bits.
- Push on kbd_valid.
- Pop on KBD_DATA read when not empty.
- Push while full with no pop: data dropped, overflow set (sticky).
- Push and pop in the same cycle, including when full: both happen, count unchanged, no overflow.
- Pop while empty: returns 0, no pointer change.
- Reset: empty, overflow=0.

Timer:
- Prescaler counts 0..TMR_PRESCALE-1. On wrap, TMR_CNT increments.
- When TMR_CNT==TMR_PERIOD and the prescaler wraps: TMR_CNT←0 and the wrap flag is set.
- Simultaneous set and W1C: set wins.
- TMR_PERIOD=0: the flag sets every prescaler wrap.
- irq = irq_en & wrap flag, registered; reset 0.

Output reset values:
- mem_ready=1, irq=0.
- d_f_mem follows decode (registers read 0).
- All strobes follow their inputs gated by decode.

Decomposition:
- Package mio_pkg holds:
  - region base/mask constants;
  - CTRL register offsets;
  - KBD_STAT and TMR_CTRL bit positions;
  - the FSM state enum.
- One sub-module, mio_kbd_fifo: parametrised DEPTH, with push/pop/full/empty/count/overflow.
- The timer and FSM stay inline.

Test Plan:
- VRAM_WAIT=2; write to C000_0010 with data 0x41:
  - mem_ready low 2 cycles, high on the 3rd;
  - wvram high only on the 3rd cycle, with d_t_vga=0x41.
- Keyboard:
  - push 0x1C, 0x32, then read 0x1014 twice → 0x1C, 0x32;
  - a third read → 0, with KBD_STAT empty=1.
- Overflow (DEPTH=8):
  - push 9 codes → KBD_STAT=0x0806 (count 8, full, overflow);
  - write 0x1018 → overflow=0;
  - push and pop in the same cycle → count stays 8.
- Timer (PRESCALE=16):
  - write TMR_PERIOD=3 and TMR_CTRL=1;
  - after 64 cycles the wrap flag is 1 and irq=1 the next cycle;
  - write TMR_CTRL=0x3 → irq drops; the flag re-sets 64 cycles later.
- Decode: reads of 0x0000_0004 (ROM), 0x0000_0804 (RAM, ram_a=1), 0x0000_7F10 (SEG), 0x0000_101C → d_f_rom, d_f_ram, d_f_seg, 0.
- Reset:
  - rst_n=0 during a VRAM wait with the FIFO holding 3 entries → next cycle mem_ready=1, KBD_STAT=0x0001, CUR_ROW=0;
  - TMR_PERIOD reads 62500.
